// File: rtl/vga_controller.sv
// VGA timing generator: 25 MHz pixel enable derived from a 50 MHz clock, with h/v
// counters, sync/blank decode, a tick-advanced alignment delay and a frame counter.
module vga_controller #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic       sync_n,
  output logic       vga_clk,
  output logic       pixel_tick,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS_END = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank_n;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, blank_n: 1'b0};

  logic       tick;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic [7:0] frame_cnt;
  logic       h_wrap;
  logic       v_wrap;
  sync_t      raw;
  sync_t      dly;

  assign h_wrap = (h_count == H_LAST);
  assign v_wrap = (v_count == V_LAST);

  // Reset wins over everything, so a frame cut short by rst never reports completion.
  assign frame_start = tick & h_wrap & v_wrap & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick      <= 1'b0;
      h_count   <= '0;
      v_count   <= '0;
      frame_cnt <= '0;
    end else begin
      tick <= ~tick;
      if (frame_start) frame_cnt <= frame_cnt + 8'd1;
      if (tick) begin
        if (h_wrap) begin
          h_count <= '0;
          v_count <= v_wrap ? '0 : v_count + 10'd1;
        end else begin
          h_count <= h_count + 10'd1;
        end
      end
    end
  end

  always_comb begin
    raw.hsync   = !((h_count >= HS_START) && (h_count < HS_END));
    raw.vsync   = !((v_count >= VS_START) && (v_count < VS_END));
    raw.blank_n = (h_count < H_VIS_END) && (v_count < V_VIS_END);
  end

  // Delay line keeps sync/blank aligned with a downstream pixel path of equal latency.
  if (PIPE_DELAY == 0) begin : g_nodly
    assign dly = raw;
  end else begin : g_dly
    sync_t [PIPE_DELAY-1:0] pipe;

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < PIPE_DELAY; i++) pipe[i] <= SYNC_IDLE;
      end else if (tick) begin
        pipe[0] <= raw;
        for (int i = 1; i < PIPE_DELAY; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign dly = pipe[PIPE_DELAY-1];
  end

  assign x           = h_count;
  assign y           = v_count;
  assign hsync       = dly.hsync;
  assign vsync       = dly.vsync;
  assign blank_n     = dly.blank_n;
  assign sync_n      = 1'b0;
  assign vga_clk     = tick;
  assign pixel_tick  = tick;
  assign frame_count = frame_cnt;

endmodule

// File: tb/tb_vga_controller.sv
// Randomized-reset bench for vga_controller: four parameterisations checked every
// cycle against a time-based reference model through per-instance scoreboards.
module tb_vga_controller;

  localparam int N = 4;
  // HA HF HS HB VA VF VS VB D
  localparam int CFG [N][9] = '{
    '{8, 2, 3, 3, 6, 1, 2, 2, 1},
    '{8, 2, 3, 3, 6, 1, 2, 2, 2},
    '{1, 1, 1, 1, 1, 1, 1, 1, 0},
    '{640, 16, 96, 48, 480, 10, 2, 33, 1}
  };

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       bn;
    logic       sn;
    logic       vc;
    logic       pt;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] x_w [N];
  logic [9:0] y_w [N];
  logic [7:0] fc_w [N];
  logic       hs_w [N], vs_w [N], bn_w [N], sn_w [N], vc_w [N], pt_w [N], fs_w [N];
  obs_t       act [N];
  obs_t       sb [N][$];
  int         t [N];
  int         ncmp = 0;
  int         nfail = 0;

  always #5 clk = ~clk;

  vga_controller #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(6), .V_FP(1),
                   .V_SYNC(2), .V_BP(2), .PIPE_DELAY(1)) dut0 (
    .clk(clk), .rst(rst), .x(x_w[0]), .y(y_w[0]), .hsync(hs_w[0]), .vsync(vs_w[0]),
    .blank_n(bn_w[0]), .sync_n(sn_w[0]), .vga_clk(vc_w[0]), .pixel_tick(pt_w[0]),
    .frame_start(fs_w[0]), .frame_count(fc_w[0]));

  vga_controller #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(6), .V_FP(1),
                   .V_SYNC(2), .V_BP(2), .PIPE_DELAY(2)) dut1 (
    .clk(clk), .rst(rst), .x(x_w[1]), .y(y_w[1]), .hsync(hs_w[1]), .vsync(vs_w[1]),
    .blank_n(bn_w[1]), .sync_n(sn_w[1]), .vga_clk(vc_w[1]), .pixel_tick(pt_w[1]),
    .frame_start(fs_w[1]), .frame_count(fc_w[1]));

  vga_controller #(.H_ACTIVE(1), .H_FP(1), .H_SYNC(1), .H_BP(1), .V_ACTIVE(1), .V_FP(1),
                   .V_SYNC(1), .V_BP(1), .PIPE_DELAY(0)) dut2 (
    .clk(clk), .rst(rst), .x(x_w[2]), .y(y_w[2]), .hsync(hs_w[2]), .vsync(vs_w[2]),
    .blank_n(bn_w[2]), .sync_n(sn_w[2]), .vga_clk(vc_w[2]), .pixel_tick(pt_w[2]),
    .frame_start(fs_w[2]), .frame_count(fc_w[2]));

  vga_controller dut3 (
    .clk(clk), .rst(rst), .x(x_w[3]), .y(y_w[3]), .hsync(hs_w[3]), .vsync(vs_w[3]),
    .blank_n(bn_w[3]), .sync_n(sn_w[3]), .vga_clk(vc_w[3]), .pixel_tick(pt_w[3]),
    .frame_start(fs_w[3]), .frame_count(fc_w[3]));

  for (genvar g = 0; g < N; g++) begin : g_obs
    assign act[g] = {x_w[g], y_w[g], hs_w[g], vs_w[g], bn_w[g], sn_w[g], vc_w[g],
                     pt_w[g], fs_w[g], fc_w[g]};
  end

  task automatic chk(input bit ok, input string what);
    ncmp++;
    if (!ok) begin
      nfail++;
      $display("FAIL %s at %0t", what, $time);
    end
  endtask

  // Expected outputs as a pure function of clocks elapsed since the last reset edge.
  function automatic obs_t model(int i, int tt, logic r);
    obs_t e;
    int ht, vt, p, q, hq, vq;
    ht = CFG[i][0] + CFG[i][1] + CFG[i][2] + CFG[i][3];
    vt = CFG[i][4] + CFG[i][5] + CFG[i][6] + CFG[i][7];
    p  = tt / 2;
    e.x  = 10'(p % ht);
    e.y  = 10'((p / ht) % vt);
    e.vc = 1'(tt % 2);
    e.pt = 1'(tt % 2);
    e.sn = 1'b0;
    e.fc = 8'((tt / (2 * ht * vt)) % 256);
    e.fs = (tt % 2 == 1) && (p % ht == ht - 1) && ((p / ht) % vt == vt - 1) && !r;
    q = p - CFG[i][8];
    if (q < 0) begin
      e.hs = 1'b1;
      e.vs = 1'b1;
      e.bn = 1'b0;
    end else begin
      hq = q % ht;
      vq = (q / ht) % vt;
      e.hs = !(hq >= CFG[i][0] + CFG[i][1] && hq < CFG[i][0] + CFG[i][1] + CFG[i][2]);
      e.vs = !(vq >= CFG[i][4] + CFG[i][5] && vq < CFG[i][4] + CFG[i][5] + CFG[i][6]);
      e.bn = (hq < CFG[i][0]) && (vq < CFG[i][4]);
    end
    return e;
  endfunction

  // Advance elapsed time on the edge, then push expectations once rst for the new cycle is settled.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) t[i] = rst ? 0 : t[i] + 1;
    #2;
    for (int i = 0; i < N; i++) sb[i].push_back(model(i, t[i], rst));
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (sb[i].size() > 0) begin
        obs_t e;
        e = sb[i].pop_front();
        ncmp++;
        if (act[i] !== e) begin
          nfail++;
          if (nfail <= 30)
            $display("FAIL dut%0d t=%0d got x=%0d y=%0d hs=%b vs=%b bn=%b sn=%b vc=%b pt=%b fs=%b fc=%0d expected x=%0d y=%0d hs=%b vs=%b bn=%b sn=%b vc=%b pt=%b fs=%b fc=%0d",
                     i, t[i], act[i].x, act[i].y, act[i].hs, act[i].vs, act[i].bn, act[i].sn,
                     act[i].vc, act[i].pt, act[i].fs, act[i].fc, e.x, e.y, e.hs, e.vs, e.bn,
                     e.sn, e.vc, e.pt, e.fs, e.fc);
        end
      end
    end
  end

  initial begin
    int w;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk(x_w[3] === 10'd0, "reset x");
    chk(y_w[3] === 10'd0, "reset y");
    chk(hs_w[3] === 1'b1, "reset hsync");
    chk(vs_w[3] === 1'b1, "reset vsync");
    chk(bn_w[3] === 1'b0, "reset blank_n");
    chk(fc_w[3] === 8'd0, "reset frame_count");
    chk(pt_w[3] === 1'b0, "reset pixel_tick");
    chk(sn_w[3] === 1'b0, "reset sync_n");
    chk(hs_w[0] === 1'b1 && vs_w[0] === 1'b1 && bn_w[0] === 1'b0, "reset sync idle dut0");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk(x_w[3] === 10'd0 && pt_w[3] === 1'b1, "first edge after reset");
    @(posedge clk);
    #1;
    chk(x_w[3] === 10'd1, "x=1 on second edge after reset");
    w = 0;
    while (fs_w[2] !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk(fs_w[2] === 1'b1, "timeout waiting for frame_start");
    chk(fc_w[2] === 8'd0, "frame_count before first frame end");
    @(negedge clk);
    chk(fc_w[2] === 8'd1, "frame_count after first frame");
    @(posedge clk);
    repeat (1640) @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(50, 700)) @(posedge clk);
      #1 rst = 1'b1;
      repeat ($urandom_range(1, 2)) @(posedge clk);
      #1 rst = 1'b0;
    end
    // Long uninterrupted run: the tiny instance completes 256+ frames and wraps frame_count.
    repeat (8300) @(posedge clk);
    repeat (3) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
